caliptra_apb_completer: RTL and testbench
=========================================

Name: caliptra_apb_completer

Overview:
- APB completer (responder): terminates one APB requester port and converts each transfer into a single valid/ack request on a simple internal register bus.
- Performs address-range, alignment and PAUSER checks, and applies a request timeout.
- Instantiated behind the Caliptra APB arbiter output to front a register block; it is the far end of the arbitrated APB link.

Parameters:
- APB_ADDR_WIDTH, 32, APB address width.
- APB_DATA_WIDTH, 32, APB and register data width.
- APB_STRB_WIDTH, 4, write strobe width (APB_DATA_WIDTH/8).
- REG_ADDR_WIDTH, 12, register-space byte address width; window size is 2^REG_ADDR_WIDTH bytes.
- BASE_ADDR, 32'h0000_0000, window base; must be aligned to 2^REG_ADDR_WIDTH.
- TIMEOUT_CYCLES, 255, maximum cycles o_req_valid waits for ack; 0 disables the timeout.
- PAUSER_CHECK_EN, 0, 1 enables the PAUSER check.
- PAUSER_ALLOWED, 32'hFFFF_FFFF, only PAUSER value accepted when the check is enabled.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_apb_paddr  in  APB_ADDR_WIDTH  address
- i_apb_pprot  in  3  protection (ignored)
- i_apb_psel  in  1  select
- i_apb_penable  in  1  enable
- i_apb_pwrite  in  1  1 = write
- i_apb_pwdata  in  APB_DATA_WIDTH  write data
- i_apb_pstrb  in  APB_STRB_WIDTH  write strobes
- i_apb_pauser  in  32  user attribute
- o_apb_pready  out  1  transfer complete
- o_apb_pslverr  out  1  transfer error
- o_apb_prdata  out  APB_DATA_WIDTH  read data
- o_req_valid  out  1  register request valid
- o_req_write  out  1  request is a write
- o_req_addr  out  REG_ADDR_WIDTH  byte offset, paddr[REG_ADDR_WIDTH-1:0]
- o_req_wdata  out  APB_DATA_WIDTH  write data
- o_req_wstrb  out  APB_STRB_WIDTH  strobes (forced to 0 on reads)
- i_req_ack  in  1  request accepted/completed
- i_req_rdata  in  APB_DATA_WIDTH  read data, valid with ack
- i_req_err  in  1  error, valid with ack

Behaviour:

Reset:
- i_reset asynchronously forces state to ST_IDLE.
- All o_req_* outputs, response registers and the timeout counter reset to 0.
- APB outputs are 0 while in reset.
- A reset mid-transfer drops the request immediately; no pready is issued.

Setup phase (ST_IDLE, psel=1 and penable=0):
- Register paddr, pwrite, pwdata and pstrb.
- Decode error if any of the following hold:
  - paddr[1:0] != 0;
  - paddr is outside [BASE_ADDR, BASE_ADDR + 2^REG_ADDR_WIDTH);
  - PAUSER_CHECK_EN=1 and pauser != PAUSER_ALLOWED.
- On a decode error go to ST_ERR; otherwise go to ST_REQ.
- psel=1 with penable=1 seen in ST_IDLE is a protocol violation: ignore it and stay in ST_IDLE.

ST_REQ:
- o_req_valid=1 (registered); request fields are held stable.
- The counter increments each cycle the request is not acked.
- i_req_ack=1: capture i_req_rdata (reads only; writes capture 0) and i_req_err, deassert valid, go to ST_RESP.
- Counter reaches TIMEOUT_CYCLES with no ack: deassert valid, capture err=1 and rdata=0, go to ST_RESP.
- Ack and timeout in the same cycle: the ack wins.
- psel dropping during ST_REQ does not abort the request; after ack or timeout go to ST_IDLE instead of ST_RESP.

ST_RESP / ST_ERR:
- o_apb_pready = psel & penable.
- o_apb_pslverr = pready & captured err (ST_ERR: err=1).
- o_apb_prdata = captured rdata when pready & read, otherwise 0.
- Return to ST_IDLE on the pready cycle, or immediately if psel=0.

Latency:
- Error path: zero wait states; pready in the first access cycle.
- Good path: o_req_valid in the first access cycle; ack in cycle N (N≥0 after valid) gives pready in cycle N+1, so the minimum is one wait state.

Output rules:
- o_apb_pready, o_apb_pslverr and o_apb_prdata are 0 in all other states.
- Back-to-back transfers: a new setup is accepted in the cycle after pready.

Decomposition:
- caliptra_apb_completer_pkg holds:
  - the state enum (ST_IDLE, ST_REQ, ST_RESP, ST_ERR);
  - a timeout counter width constant, $clog2(TIMEOUT_CYCLES+1), minimum 1.
- One combinational sub-module, caliptra_apb_completer_decode, performs the alignment, range and PAUSER checks and outputs the decode error and the offset.

Test Plan:
- Write: paddr=0x0000_0010, pwdata=0xDEAD_BEEF, pstrb=0xF, ack in the first valid cycle -> o_req_addr=0x010, o_req_wdata=0xDEAD_BEEF, o_req_wstrb=0xF, pready one cycle later, pslverr=0, prdata=0.
- Read: paddr=0x0000_0FFC, ack after 3 cycles with i_req_rdata=0x1234_5678 -> o_req_wstrb=0, prdata=0x1234_5678 exactly on the pready cycle, 4 wait states.
- Decode errors: paddr=0x0000_0012, then paddr=0x0000_1000 -> pready and pslverr in the first access cycle, o_req_valid never asserted.
- Timeout: TIMEOUT_CYCLES=8, no ack -> valid high 8 cycles, then pready with pslverr=1, prdata=0; a subsequent good read completes normally.
- PAUSER: PAUSER_CHECK_EN=1, PAUSER_ALLOWED=0x1, pauser=0x2 -> pslverr, no request; pauser=0x1 -> normal completion. Also ack with i_req_err=1 -> pslverr=1, prdata=0.
- Reset: assert i_reset during ST_REQ -> o_req_valid drops asynchronously, no pready; after release, the next write completes with correct fields.

Source files
------------

// File: rtl/caliptra_apb_completer_pkg.sv
// Shared types and helpers for the Caliptra APB completer.
// Holds the FSM state encoding and the timeout counter sizing rule.
package caliptra_apb_completer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_ERR
    } state_t;

    // Counter must be able to hold TIMEOUT_CYCLES; a disabled timeout still needs one bit.
    function automatic int timeout_cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int TIMEOUT_CNT_W_DEFAULT = timeout_cnt_width(255);

endpackage

// File: rtl/caliptra_apb_completer_decode.sv
// Combinational setup-phase decode: alignment, window range and PAUSER checks,
// plus extraction of the register byte offset.
module caliptra_apb_completer_decode
    import caliptra_apb_completer_pkg::*;
#(
    parameter int                        APB_ADDR_WIDTH  = 32,
    parameter int                        REG_ADDR_WIDTH  = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                        PAUSER_CHECK_EN = 0,
    parameter logic [31:0]               PAUSER_ALLOWED  = 32'hFFFF_FFFF
) (
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pauser,
    output logic                      dec_err,
    output logic [REG_ADDR_WIDTH-1:0] offset
);

    // BASE_ADDR is window-aligned, so range membership is a compare of the bits above the window.
    localparam logic [APB_ADDR_WIDTH-1:0] WIN_MASK =
        APB_ADDR_WIDTH'((64'd1 << REG_ADDR_WIDTH) - 64'd1);

    logic misaligned;
    logic out_of_range;
    logic bad_user;

    assign misaligned   = (paddr[1:0] != 2'b00);
    assign out_of_range = ((paddr & ~WIN_MASK) != (BASE_ADDR & ~WIN_MASK));
    assign bad_user     = (PAUSER_CHECK_EN != 0) && (pauser != PAUSER_ALLOWED);

    assign dec_err = misaligned | out_of_range | bad_user;
    assign offset  = paddr[REG_ADDR_WIDTH-1:0];

endmodule

// File: rtl/caliptra_apb_completer.sv
// APB completer that turns each APB transfer into one valid/ack request on an
// internal register bus, with decode checks and a request timeout.
module caliptra_apb_completer
    import caliptra_apb_completer_pkg::*;
#(
    parameter int                        APB_ADDR_WIDTH  = 32,
    parameter int                        APB_DATA_WIDTH  = 32,
    parameter int                        APB_STRB_WIDTH  = 4,
    parameter int                        REG_ADDR_WIDTH  = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                        TIMEOUT_CYCLES  = 255,
    parameter int                        PAUSER_CHECK_EN = 0,
    parameter logic [31:0]               PAUSER_ALLOWED  = 32'hFFFF_FFFF
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [APB_ADDR_WIDTH-1:0] i_apb_paddr,
    input  logic [2:0]                i_apb_pprot,
    input  logic                      i_apb_psel,
    input  logic                      i_apb_penable,
    input  logic                      i_apb_pwrite,
    input  logic [APB_DATA_WIDTH-1:0] i_apb_pwdata,
    input  logic [APB_STRB_WIDTH-1:0] i_apb_pstrb,
    input  logic [31:0]               i_apb_pauser,
    output logic                      o_apb_pready,
    output logic                      o_apb_pslverr,
    output logic [APB_DATA_WIDTH-1:0] o_apb_prdata,
    output logic                      o_req_valid,
    output logic                      o_req_write,
    output logic [REG_ADDR_WIDTH-1:0] o_req_addr,
    output logic [APB_DATA_WIDTH-1:0] o_req_wdata,
    output logic [APB_STRB_WIDTH-1:0] o_req_wstrb,
    input  logic                      i_req_ack,
    input  logic [APB_DATA_WIDTH-1:0] i_req_rdata,
    input  logic                      i_req_err
);

    localparam int                CNT_W      = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST   =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic                      dropped;
    logic                      resp_err;
    logic [APB_DATA_WIDTH-1:0] resp_rdata;
    logic                      dec_err;
    logic [REG_ADDR_WIDTH-1:0] dec_offset;
    logic                      resp_phase;
    logic                      setup;
    logic                      timed_out;
    logic                      unused_pprot;

    assign unused_pprot = ^i_apb_pprot;

    caliptra_apb_completer_decode #(
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .BASE_ADDR      (BASE_ADDR),
        .PAUSER_CHECK_EN(PAUSER_CHECK_EN),
        .PAUSER_ALLOWED (PAUSER_ALLOWED)
    ) u_decode (
        .paddr  (i_apb_paddr),
        .pauser (i_apb_pauser),
        .dec_err(dec_err),
        .offset (dec_offset)
    );

    assign setup     = i_apb_psel & ~i_apb_penable;
    assign timed_out = TIMEOUT_EN && (cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dropped     <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            o_req_valid <= 1'b0;
            o_req_write <= 1'b0;
            o_req_addr  <= '0;
            o_req_wdata <= '0;
            o_req_wstrb <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // psel with penable already high here is a protocol violation and is ignored.
                    if (setup) begin
                        o_req_write <= i_apb_pwrite;
                        o_req_addr  <= dec_offset;
                        o_req_wdata <= i_apb_pwdata;
                        o_req_wstrb <= i_apb_pwrite ? i_apb_pstrb : '0;
                        cnt         <= '0;
                        dropped     <= 1'b0;
                        if (dec_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_ERR;
                        end else begin
                            o_req_valid <= 1'b1;
                            state       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (!i_apb_psel) begin
                        dropped <= 1'b1;
                    end
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (i_req_ack) begin
                        o_req_valid <= 1'b0;
                        resp_err    <= i_req_err;
                        resp_rdata  <= o_req_write ? '0 : i_req_rdata;
                        state       <= (dropped || !i_apb_psel) ? ST_IDLE : ST_RESP;
                    end else if (timed_out) begin
                        o_req_valid <= 1'b0;
                        resp_err    <= 1'b1;
                        resp_rdata  <= '0;
                        state       <= (dropped || !i_apb_psel) ? ST_IDLE : ST_RESP;
                    end else if (TIMEOUT_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP, ST_ERR: begin
                    if (!i_apb_psel || i_apb_penable) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign resp_phase    = (state == ST_RESP) || (state == ST_ERR);
    assign o_apb_pready  = resp_phase & i_apb_psel & i_apb_penable;
    assign o_apb_pslverr = o_apb_pready & resp_err;
    assign o_apb_prdata  = (o_apb_pready && !o_req_write) ? resp_rdata : '0;

endmodule

// File: tb/tb_caliptra_apb_completer.sv
// Self-checking bench for caliptra_apb_completer: table-driven APB transfers
// with a response scoreboard, plus hand-written reset and protocol sequences.
module tb_caliptra_apb_completer;

    typedef struct {
        logic [31:0] paddr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] pauser;
        int          ack_delay;
        logic [31:0] ack_rdata;
        logic        ack_err;
        int          exp_valid;
        logic [11:0] exp_addr;
        int          exp_waits;
        logic        exp_slverr;
        logic [31:0] exp_prdata;
    } vec_t;

    typedef struct {
        int          valid_cycles;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0;
    logic [2:0]  pprot = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] pauser = 32'h1;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        req_valid;
    logic        req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ack = 1'b0;
    logic [31:0] req_rdata = '0;
    logic        req_err = 1'b0;

    int          errors = 0;
    int          checks = 0;
    resp_t       exp_q[$];
    vec_t        vecs[10];

    int          ack_delay = -1;
    logic [31:0] ack_rdata = '0;
    logic        ack_err = 1'b0;
    int          valid_cnt = 0;

    always #5 clk = ~clk;

    caliptra_apb_completer #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .APB_STRB_WIDTH (4),
        .REG_ADDR_WIDTH (12),
        .BASE_ADDR      (32'h0000_0000),
        .TIMEOUT_CYCLES (8),
        .PAUSER_CHECK_EN(1),
        .PAUSER_ALLOWED (32'h1)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_apb_paddr  (paddr),
        .i_apb_pprot  (pprot),
        .i_apb_psel   (psel),
        .i_apb_penable(penable),
        .i_apb_pwrite (pwrite),
        .i_apb_pwdata (pwdata),
        .i_apb_pstrb  (pstrb),
        .i_apb_pauser (pauser),
        .o_apb_pready (pready),
        .o_apb_pslverr(pslverr),
        .o_apb_prdata (prdata),
        .o_req_valid  (req_valid),
        .o_req_write  (req_write),
        .o_req_addr   (req_addr),
        .o_req_wdata  (req_wdata),
        .o_req_wstrb  (req_wstrb),
        .i_req_ack    (req_ack),
        .i_req_rdata  (req_rdata),
        .i_req_err    (req_err)
    );

    // Register-side responder: acks in the ack_delay-th valid cycle of each request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (req_valid) begin
                if (valid_cnt == ack_delay) begin
                    req_ack   = 1'b1;
                    req_rdata = ack_rdata;
                    req_err   = ack_err;
                end else begin
                    req_ack   = 1'b0;
                    req_rdata = '0;
                    req_err   = 1'b0;
                end
                valid_cnt++;
            end else begin
                req_ack   = 1'b0;
                req_rdata = '0;
                req_err   = 1'b0;
                valid_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        resp_t e;
        e.valid_cycles = v.exp_valid;
        e.waits        = v.exp_waits;
        e.slverr       = v.exp_slverr;
        e.prdata       = v.exp_prdata;
        exp_q.push_back(e);
        ack_delay = v.ack_delay;
        ack_rdata = v.ack_rdata;
        ack_err   = v.ack_err;
        @(posedge clk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = v.paddr;
        pwrite  = v.write;
        pwdata  = v.wdata;
        pstrb   = v.strb;
        pauser  = v.pauser;
    endtask

    task automatic checkOutput(input vec_t v);
        int    valid_seen = 0;
        int    waits = 0;
        bit    done = 0;
        bit    fields_checked = 0;
        resp_t e;
        @(posedge clk);
        #1;
        penable = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (req_valid) begin
                if (!fields_checked) begin
                    check("req_write", 32'(req_write), 32'(v.write));
                    check("req_addr", 32'(req_addr), 32'(v.exp_addr));
                    check("req_wstrb", 32'(req_wstrb), v.write ? 32'(v.strb) : 32'h0);
                    if (v.write) check("req_wdata", req_wdata, v.wdata);
                    fields_checked = 1;
                end
                valid_seen++;
            end
            if (pready) begin
                e = exp_q.pop_front();
                check("valid_cycles", 32'(valid_seen), 32'(e.valid_cycles));
                check("wait_states", 32'(waits), 32'(e.waits));
                check("pslverr", 32'(pslverr), 32'(e.slverr));
                check("prdata", prdata, e.prdata);
                done = 1;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            check("pready_seen", 32'h0, 32'h1);
            void'(exp_q.pop_front());
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //         paddr          wr    wdata          strb  pauser  dly  ack_rdata      err  valid addr    waits slverr prdata
        vecs[0] = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h1,  0, 32'h5555_5555, 1'b0, 1, 12'h010, 1, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_0FFC, 1'b0, 32'h0,         4'hF, 32'h1,  3, 32'h1234_5678, 1'b0, 4, 12'hFFC, 4, 1'b0, 32'h1234_5678};
        vecs[2] = '{32'h0000_0012, 1'b0, 32'h0,         4'h0, 32'h1,  0, 32'h1111_1111, 1'b0, 0, 12'h012, 0, 1'b1, 32'h0};
        vecs[3] = '{32'h0000_1000, 1'b1, 32'hAAAA_AAAA, 4'hF, 32'h1,  0, 32'h0,         1'b0, 0, 12'h000, 0, 1'b1, 32'h0};
        vecs[4] = '{32'h0000_0020, 1'b0, 32'h0,         4'h0, 32'h1, -1, 32'h0,         1'b0, 8, 12'h020, 8, 1'b1, 32'h0};
        vecs[5] = '{32'h0000_0024, 1'b0, 32'h0,         4'h0, 32'h1,  1, 32'hA5A5_0F0F, 1'b0, 2, 12'h024, 2, 1'b0, 32'hA5A5_0F0F};
        vecs[6] = '{32'h0000_0030, 1'b0, 32'h0,         4'h0, 32'h2,  0, 32'h2222_2222, 1'b0, 0, 12'h030, 0, 1'b1, 32'h0};
        vecs[7] = '{32'h0000_0034, 1'b1, 32'h0000_00FF, 4'h3, 32'h1,  0, 32'h0,         1'b0, 1, 12'h034, 1, 1'b0, 32'h0};
        vecs[8] = '{32'h0000_0038, 1'b1, 32'h0BAD_CAFE, 4'hC, 32'h1,  2, 32'hFFFF_FFFF, 1'b1, 3, 12'h038, 3, 1'b1, 32'h0};
        vecs[9] = '{32'h0000_003C, 1'b0, 32'h0,         4'h0, 32'h1,  0, 32'hCAFE_F00D, 1'b0, 1, 12'h03C, 1, 1'b0, 32'hCAFE_F00D};

        // Outputs must be quiet while reset is held, even with an access phase on the bus.
        psel    = 1'b1;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_valid", 32'(req_valid), 32'h0);
        check("reset_pready", 32'(pready), 32'h0);
        check("reset_pslverr", 32'(pslverr), 32'h0);
        check("reset_prdata", prdata, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        rst     = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // psel+penable seen in idle without a setup phase must be ignored.
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        psel    = 1'b1;
        penable = 1'b1;
        paddr   = 32'h0000_0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("protocol_no_valid", 32'(req_valid), 32'h0);
            check("protocol_no_pready", 32'(pready), 32'h0);
        end
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;

        // Reset in the middle of a pending request drops it at once with no response.
        ack_delay = -1;
        @(posedge clk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 32'h0000_0040;
        pwrite  = 1'b1;
        pwdata  = 32'h7777_7777;
        pstrb   = 4'hF;
        pauser  = 32'h1;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(negedge clk);
        check("rst_mid_valid_before", 32'(req_valid), 32'h1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid_async", 32'(req_valid), 32'h0);
        check("rst_mid_pready", 32'(pready), 32'h0);
        @(posedge clk);
        #1;
        check("rst_mid_pready_held", 32'(pready), 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(vecs[0]);
        checkOutput(vecs[0]);
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
